bennett_phase_clock: RTL and testbench



---
 rtl/bennett_phase_clock.sv | 74 +++++++
 tb/tb_bennett_phase_clock.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bennett_phase_clock.sv
// rtl/bennett_phase_clock.sv - Bennett-clocking cumulative phase generator
module bennett_phase_clock #(
    parameter int PHASES = 10,
    parameter int HOLD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PHASES-1:0] clkp,
    output logic              Mclk,
    output logic              instFlag
);

    // One Bennett cycle: IDLE, PHASES forward steps, HOLD dwell steps, PHASES reverse steps
    localparam int L  = 2 * PHASES + HOLD + 1;
    localparam int CW = $clog2(L);

    localparam logic [CW-1:0] C_LAST      = CW'(L - 1);
    localparam logic [CW-1:0] C_FWD_END   = CW'(PHASES);
    localparam logic [CW-1:0] C_DWELL_END = CW'(PHASES + HOLD);
    // In REV the number of asserted phases is C_REV_BASE - c
    localparam logic [CW-1:0] C_REV_BASE  = CW'(2 * PHASES + HOLD);

    logic [CW-1:0]     c_q, c_d;
    logic [CW-1:0]     ones;
    logic [PHASES-1:0] clkp_q, clkp_d;
    logic              mclk_q, mclk_d;
    logic              inst_q, inst_d;

    // Next step count: free-running modulo-L counter
    always_comb begin
        c_d = c_q + 1'b1;
        if (c_q == C_LAST) begin
            c_d = '0;
        end
    end

    // Decode the next count so the registered outputs line up with c in the same cycle
    always_comb begin
        ones = '0;
        if (c_d <= C_FWD_END) begin
            ones = c_d;
        end else if (c_d <= C_DWELL_END) begin
            ones = C_FWD_END;
        end else begin
            ones = C_REV_BASE - c_d;
        end
        clkp_d = '0;
        for (int i = 0; i < PHASES; i++) begin
            clkp_d[i] = (CW'(i) < ones);
        end
        mclk_d = (c_d > C_FWD_END);
        inst_d = (c_d == '0);
    end

    // State and output registers; reset aborts straight to IDLE with no retract
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q    <= '0;
            clkp_q <= '0;
            mclk_q <= 1'b0;
            inst_q <= 1'b1;
        end else begin
            c_q    <= c_d;
            clkp_q <= clkp_d;
            mclk_q <= mclk_d;
            inst_q <= inst_d;
        end
    end

    assign clkp     = clkp_q;
    assign Mclk     = mclk_q;
    assign instFlag = inst_q;

endmodule

// File: tb/tb_bennett_phase_clock.sv
// tb/tb_bennett_phase_clock.sv - directed self-checking bench for bennett_phase_clock
module tb_bennett_phase_clock;

    logic       clk;
    logic       reset;
    logic [9:0] clkp1;
    logic       mclk1;
    logic       inst1;
    logic [3:0] clkp2;
    logic       mclk2;
    logic       inst2;

    int n_checks;
    int n_fail;
    int cyc;

    bennett_phase_clock u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .clkp     (clkp1),
        .Mclk     (mclk1),
        .instFlag (inst1)
    );

    bennett_phase_clock #(.PHASES(4), .HOLD(3)) u_dut2 (
        .clk      (clk),
        .reset    (reset),
        .clkp     (clkp2),
        .Mclk     (mclk2),
        .instFlag (inst2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Continuous ordering checker on the default instance
    logic       chk_en;
    logic       prev_ok;
    logic [9:0] prev_clkp;
    always @(negedge clk) begin
        if (chk_en) begin
            check("thermometer", 32'((clkp1 & (clkp1 + 10'd1)) == 10'd0), 32'd1);
            if (prev_ok) begin
                check("one_bit_step", 32'($countones(clkp1 ^ prev_clkp) <= 1), 32'd1);
            end
            prev_clkp = clkp1;
            prev_ok   = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
    end

    // Edge-time recorder for each phase of the default instance
    int         rise_t [10];
    int         fall_t [10];
    logic [9:0] last1;
    always @(negedge clk) begin
        for (int i = 0; i < 10; i++) begin
            if (clkp1[i] && !last1[i]) rise_t[i] = cyc;
            if (!clkp1[i] && last1[i]) fall_t[i] = cyc;
        end
        last1 = clkp1;
    end

    logic [3:0] t2_clkp [12] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
    logic       t2_mclk [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [31:0] e;
        int cnt, mh, g, t;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        chk_en    = 1'b0;
        prev_ok   = 1'b0;
        prev_clkp = '0;
        last1     = '0;
        reset     = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_clkp", 32'(clkp1), 32'h0);
        check("rst_mclk", 32'(mclk1), 32'd0);
        check("rst_inst", 32'(inst1), 32'd1);
        check("rst_clkp2", 32'(clkp2), 32'h0);
        check("rst_inst2", 32'(inst2), 32'd1);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Forward sweep
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e = (32'd1 << k) - 32'd1;
            check("fwd_clkp", 32'(clkp1), e);
            check("fwd_mclk", 32'(mclk1), 32'd0);
            check("fwd_inst", 32'(inst1), 32'd0);
        end
        // Reverse sweep
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            e = (32'd1 << (9 - j)) - 32'd1;
            check("rev_clkp", 32'(clkp1), e);
            check("rev_mclk", 32'(mclk1), 32'd1);
            check("rev_inst", 32'(inst1), 32'd0);
        end
        @(negedge clk);
        check("idle_clkp", 32'(clkp1), 32'h0);
        check("idle_mclk", 32'(mclk1), 32'd0);
        check("idle_inst", 32'(inst1), 32'd1);

        // Period, Mclk high time and gated window over 5 cycles
        for (int n = 0; n < 5; n++) begin
            cnt = 0; mh = 0; g = 0;
            do begin
                @(negedge clk);
                cnt++;
                if (mclk1) mh++;
                if (clkp1[6] && !mclk1) g++;
            end while (!inst1 && cnt < 60);
            check("period", 32'(cnt), 32'd21);
            check("mclk_high", 32'(mh), 32'd10);
            check("gate6", 32'(g), 32'd4);
        end

        check("rise_2_4", 32'(rise_t[4] - rise_t[2]), 32'd2);
        check("rise_4_6", 32'(rise_t[6] - rise_t[4]), 32'd2);
        check("rise_6_8", 32'(rise_t[8] - rise_t[6]), 32'd2);
        check("rise_8_9", 32'(rise_t[9] - rise_t[8]), 32'd1);
        check("high_p0", 32'(fall_t[0] - rise_t[0]), 32'd19);
        check("high_p9", 32'(fall_t[9] - rise_t[9]), 32'd1);
        check("high_p5", 32'(fall_t[5] - rise_t[5]), 32'd9);

        // PHASES=4, HOLD=3 instance: two full cycles against a hand table
        chk_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 24; r++) begin
            if (r != 0) @(negedge clk);
            check("p4_clkp", 32'(clkp2), 32'(t2_clkp[r % 12]));
            check("p4_mclk", 32'(mclk2), 32'(t2_mclk[r % 12]));
            check("p4_inst", 32'(inst2), 32'((r % 12) == 0));
        end
        chk_en = 1'b1;

        // Abort from mid-FWD
        t = 0;
        while (clkp1 !== 10'h07F && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("reach_07f", 32'(t < 40), 32'd1);
        check("at_07f_mclk", 32'(mclk1), 32'd0);
        chk_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check("abort_clkp", 32'(clkp1), 32'h0);
        check("abort_mclk", 32'(mclk1), 32'd0);
        check("abort_inst", 32'(inst1), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("restart_clkp", 32'(clkp1), 32'h001);
        check("restart_inst", 32'(inst1), 32'd0);
        check("restart_clkp2", 32'(clkp2), 32'h1);
        chk_en = 1'b1;
        @(negedge clk);
        check("restart2_clkp", 32'(clkp1), 32'h003);
        repeat (25) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
